ps2_host_tx: RTL
================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 transmitter. It sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard over the
//  shared PS2C/PS2D lines, and it is the counterpart of the PS2 receiver block. Both lines are open-drain: this block only
//  drives low, through output-enables, and the top level ties each pad as "OE ? 1'b0 : 1'bz".
//  o_Busy is high for the whole transaction; the top level uses it to blank the receiver during that window.
// PARAMETERS
//  INHIBIT_CYCLES  1440     clocks PS2C is held low before request-to-send (120 us @ 12 MHz)
//  TIMEOUT_CYCLES  180000   max clocks between device clock edges before abort (15 ms @ 12 MHz)
//  FILTER_LEN      8        consecutive equal samples needed to accept a new PS2C level
// PORTS
//  i_clk       in   1  system clock (12 MHz)
//  i_rst       in   1  synchronous reset, active-high
//  i_Start     in   1  one-cycle request; i_Data is sampled on the same edge
//  i_Data      in   8  command byte
//  i_PS2C      in   1  PS/2 clock pad (async; 2-FF synchroniser + FILTER_LEN glitch filter inside)
//  i_PS2D      in   1  PS/2 data pad (async; 2-FF synchroniser inside)
//  o_PS2C_OE   out  1  1 = pull PS2C low
//  o_PS2D_OE   out  1  1 = pull PS2D low
//  o_Busy      out  1  transaction in progress
//  o_Done      out  1  one-cycle pulse: byte sent and device ACK seen
//  o_Error     out  1  one-cycle pulse: timeout or missing ACK
// BEHAVIOUR
//  - Clock i_clk; reset synchronous, active-high.
//  - Reset: state IDLE; all outputs 0; both lines released; counters, shift register and filter cleared.
//    Reset asserted mid-frame releases both lines on the next edge and emits no pulses.
//  - IDLE: i_Start=1 latches {parity, i_Data}. Parity is odd: ~^i_Data. o_Busy=1 from the next cycle.
//    i_Start while o_Busy=1 is ignored; the latched byte does not change.
//  - INHIBIT: o_PS2C_OE=1 for exactly INHIBIT_CYCLES clocks. The last of these cycles also sets o_PS2D_OE=1 (start bit 0).
//  - REQ: o_PS2C_OE=0, o_PS2D_OE held 1. Wait for a filtered PS2C falling edge (fe).
//  - SHIFT: bit index n counts 0..9.
//    fe number 1..8 drives data bit n-1, LSB first (o_PS2D_OE = ~bit).
//    fe 9 drives the parity bit. fe 10 releases PS2D (stop bit = 1).
//    Each drive change is registered one cycle after fe; the device samples on the rising edge.
//  - ACK: on fe 11, sample the synchronised PS2D. If 0, go to WAIT_IDLE; if 1, raise o_Error and return to IDLE.
//  - WAIT_IDLE: when filtered PS2C=1 and PS2D=1, pulse o_Done, drop o_Busy and return to IDLE on the same cycle.
//  - Timeout: a counter is cleared on entering REQ and on every fe. If it reaches TIMEOUT_CYCLES in
//    REQ/SHIFT/ACK/WAIT_IDLE: release both lines, pulse o_Error, clear o_Busy, return to IDLE.
//  - o_Done and o_Error are never high in the same cycle. Both are pulses exactly 1 cycle wide.
//  - Counter widths: ceil(log2(max parameter + 1)); no wrap is possible before timeout.
// CONFIGURATION
//  PS2_TX_RETRY_EN defined:
//    - After a missing-ACK or timeout, restart once from INHIBIT with the same byte, o_Busy staying 1.
//    - o_Error pulses only if the retry also fails. A successful retry gives a single o_Done.
//    - Reset clears the retry flag.
//  PS2_TX_RETRY_EN undefined:
//    - No retry; o_Error pulses on the first failure.
// TESTING
//  1 Reset: hold i_rst 3 cycles mid-INHIBIT -> all outputs 0 the next cycle; PS2C/PS2D both released.
//  2 Send 0xED with a device model clocking at 15 kHz and ACKing -> start 0, bits 1,0,1,1,0,1,1,1, parity 1,
//    stop 1 -> o_Done pulse 1 cycle, o_Busy falls.
//  3 Send 0x00 -> parity 1. Send 0x01 -> parity 0. Check the model's byte and parity-ok flag.
//  4 Model gives no ACK (PS2D high at clock 11) -> o_Error pulse, no o_Done, lines released
//    (with PS2_TX_RETRY_EN: a second full INHIBIT is seen before o_Error).
//  5 Model never clocks after REQ -> o_Error exactly TIMEOUT_CYCLES clocks after REQ entry.
//  6 i_Start=1 with i_Data=0xFF during a 0xED frame -> ignored; the model receives 0xED only.
//  7 Glitch of 3 cycles low on PS2C during SHIFT -> not counted as fe; frame still correct.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte over open-drain PS2C/PS2D with ACK and timeout handling.
// Define PS2_TX_RETRY_EN to retry a failed frame once with the same byte before reporting an error.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 1440,
    parameter int unsigned TIMEOUT_CYCLES = 180000,
    parameter int unsigned FILTER_LEN     = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_Start,
    input  logic [7:0] i_Data,
    input  logic       i_PS2C,
    input  logic       i_PS2D,
    output logic       o_PS2C_OE,
    output logic       o_PS2D_OE,
    output logic       o_Busy,
    output logic       o_Done,
    output logic       o_Error
);

    localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned FLT_W   = $clog2(FILTER_LEN + 1);
    localparam int unsigned BIT_W   = 4;
    localparam int unsigned FRM_W   = 9;

    localparam logic [CNT_W-1:0] INH_PRE  = CNT_W'(INHIBIT_CYCLES - 2);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);
    localparam logic [BIT_W-1:0] BIT_STOP = BIT_W'(9);

`ifdef PS2_TX_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [FRM_W-1:0]   shreg_q, shreg_d;
    logic               retry_q, retry_d;
    logic               psc_oe_d, psd_oe_d, busy_d, done_d, error_d;
    logic               fail_c;

    logic               ps2c_s1, ps2c_s2, ps2c_f;
    logic               ps2d_s1, ps2d_s2;
    logic [FLT_W-1:0]   flt_cnt;
    logic               flt_hit_c;
    logic               fe_c;

    // A new PS2C level is accepted after FILTER_LEN consecutive differing samples.
    assign flt_hit_c = (ps2c_s2 != ps2c_f) && (flt_cnt == FLT_LAST);
    assign fe_c      = flt_hit_c && ps2c_f;

    // Pad synchronisers and PS2C glitch filter; idle lines read as high.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ps2c_s1 <= 1'b1;
            ps2c_s2 <= 1'b1;
            ps2d_s1 <= 1'b1;
            ps2d_s2 <= 1'b1;
            ps2c_f  <= 1'b1;
            flt_cnt <= '0;
        end else begin
            ps2c_s1 <= i_PS2C;
            ps2c_s2 <= ps2c_s1;
            ps2d_s1 <= i_PS2D;
            ps2d_s2 <= ps2d_s1;
            if (ps2c_s2 == ps2c_f) begin
                flt_cnt <= '0;
            end else if (flt_hit_c) begin
                flt_cnt <= '0;
                ps2c_f  <= ps2c_s2;
            end else begin
                flt_cnt <= flt_cnt + FLT_W'(1);
            end
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            retry_q   <= 1'b0;
            o_PS2C_OE <= 1'b0;
            o_PS2D_OE <= 1'b0;
            o_Busy    <= 1'b0;
            o_Done    <= 1'b0;
            o_Error   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            retry_q   <= retry_d;
            o_PS2C_OE <= psc_oe_d;
            o_PS2D_OE <= psd_oe_d;
            o_Busy    <= busy_d;
            o_Done    <= done_d;
            o_Error   <= error_d;
        end
    end

    // Next-state and next-output logic; cnt_q is the inhibit timer in INHIBIT and the edge timeout elsewhere.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        retry_d  = retry_q;
        psc_oe_d = o_PS2C_OE;
        psd_oe_d = o_PS2D_OE;
        busy_d   = o_Busy;
        done_d   = 1'b0;
        error_d  = 1'b0;
        fail_c   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_Start) begin
                    shreg_d  = {~^i_Data, i_Data};
                    retry_d  = 1'b0;
                    cnt_d    = '0;
                    bit_d    = '0;
                    busy_d   = 1'b1;
                    psc_oe_d = 1'b1;
                    psd_oe_d = 1'b0;
                    state_d  = S_INHIBIT;
                end
            end

            S_INHIBIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == INH_PRE) begin
                    psd_oe_d = 1'b1;
                end
                if (cnt_q == INH_LAST) begin
                    psc_oe_d = 1'b0;
                    psd_oe_d = 1'b1;
                    cnt_d    = '0;
                    bit_d    = '0;
                    state_d  = S_REQ;
                end
            end

            S_REQ: begin
                if (fe_c) begin
                    psd_oe_d = ~shreg_q[0];
                    bit_d    = BIT_W'(1);
                    cnt_d    = '0;
                    state_d  = S_SHIFT;
                end else if (cnt_q == TMO_LAST) begin
                    fail_c = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_SHIFT: begin
                if (fe_c) begin
                    cnt_d = '0;
                    if (bit_q == BIT_STOP) begin
                        psd_oe_d = 1'b0;
                        state_d  = S_ACK;
                    end else begin
                        psd_oe_d = ~shreg_q[bit_q];
                        bit_d    = bit_q + BIT_W'(1);
                    end
                end else if (cnt_q == TMO_LAST) begin
                    fail_c = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_ACK: begin
                if (fe_c) begin
                    cnt_d = '0;
                    if (!ps2d_s2) begin
                        state_d = S_WAIT_IDLE;
                    end else begin
                        fail_c = 1'b1;
                    end
                end else if (cnt_q == TMO_LAST) begin
                    fail_c = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_WAIT_IDLE: begin
                if (ps2c_f && ps2d_s2) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (cnt_q == TMO_LAST) begin
                    fail_c = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                psc_oe_d = 1'b0;
                psd_oe_d = 1'b0;
                busy_d   = 1'b0;
                state_d  = S_IDLE;
            end
        endcase

        // Failure: release both lines, then either restart the frame once or report the error.
        if (fail_c) begin
            psc_oe_d = 1'b0;
            psd_oe_d = 1'b0;
            cnt_d    = '0;
            bit_d    = '0;
            if (RETRY_EN && !retry_q) begin
                retry_d  = 1'b1;
                psc_oe_d = 1'b1;
                state_d  = S_INHIBIT;
            end else begin
                error_d = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        end
    end

endmodule
